tx_huge_page_rd_requester: RTL

Consumes the huge-page descriptors (address, qword count, to_hw flag) published by the host-programmed huge-page register stage. Walks each handed-over page and issues 64-bit Memory Read request TLPs on the TRN transmit interface. Once all requested qwords have returned as completions, it hands the page back to the host via a one-cycle to_host pulse. Pages 1 and 2 are serviced in ping-pong order, one page in flight at a time.

---
 rtl/tx_huge_page_rd_requester.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tx_huge_page_rd_requester.sv
// Huge-page read requester: splits host pages into MRd64 TLPs on TRN TX
// and hands each page back once all requested qwords have completed.
module tx_huge_page_rd_requester #(
   parameter int MAX_RD_QWORDS = 16
) (
   input  logic        trn_clk,
   input  logic        reset_n,
   input  logic [63:0] huge_page_addr_1,
   input  logic [63:0] huge_page_addr_2,
   input  logic [31:0] huge_page_qwords_1,
   input  logic [31:0] huge_page_qwords_2,
   input  logic        huge_page_to_hw_1,
   input  logic        huge_page_to_hw_2,
   output logic        huge_page_to_host_1,
   output logic        huge_page_to_host_2,
   input  logic [15:0] cfg_completer_id,
   output logic [63:0] trn_td,
   output logic [7:0]  trn_trem_n,
   output logic        trn_tsof_n,
   output logic        trn_teof_n,
   output logic        trn_tsrc_rdy_n,
   input  logic        trn_tdst_rdy_n,
   input  logic        rd_cpl_valid,
   input  logic [7:0]  rd_cpl_qwords,
   output logic        err_cpl_overflow
);

   typedef enum logic [2:0] {
      IDLE, SEL, HDR0, HDR1, WAIT_CPL, RELEASE, HOLD
   } state_t;

   localparam logic [31:0] MAX_Q = 32'(MAX_RD_QWORDS);

   state_t      state, state_nx;
   logic        cur_page;   // 0 = page 1, 1 = page 2
   logic        next_page;
   logic [63:0] cur_addr;
   logic [31:0] remaining;
   logic [31:0] expected;
   logic [32:0] rcvd;
   logic [6:0]  chunk;
   logic [4:0]  tag;
   logic        err;

   logic        pick_1, pick_2;
   logic        xfer;
   logic        last_chunk;
   logic [31:0] to_bound;
   logic [31:0] lim;
   logic [31:0] chunk_c;
   logic [9:0]  len_dw;

   always_comb begin
      pick_1 = 1'b0;
      pick_2 = 1'b0;
      if (!next_page) begin
         pick_1 = huge_page_to_hw_1;
         pick_2 = !huge_page_to_hw_1 && huge_page_to_hw_2;
      end else begin
         pick_2 = huge_page_to_hw_2;
         pick_1 = !huge_page_to_hw_2 && huge_page_to_hw_1;
      end
   end

   // Largest request that stays inside the current 4 KB block
   always_comb begin
      to_bound = 32'd512 - {23'd0, cur_addr[11:3]};
      lim      = (MAX_Q < to_bound) ? MAX_Q : to_bound;
      chunk_c  = (remaining < lim) ? remaining : lim;
   end

   assign xfer       = !trn_tdst_rdy_n;
   assign last_chunk = (remaining == {25'd0, chunk});
   assign len_dw     = {2'b00, chunk, 1'b0};

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     if (pick_1 || pick_2) state_nx = SEL;
         SEL:      state_nx = (remaining == 32'd0) ? WAIT_CPL : HDR0;
         HDR0:     if (xfer) state_nx = HDR1;
         HDR1:     if (xfer) state_nx = last_chunk ? WAIT_CPL : SEL;
         WAIT_CPL: if (rcvd >= {1'b0, expected}) state_nx = RELEASE;
         RELEASE:  state_nx = HOLD;
         HOLD:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_page  <= 1'b0;
         next_page <= 1'b0;
         cur_addr  <= '0;
         remaining <= '0;
         expected  <= '0;
         rcvd      <= '0;
         chunk     <= '0;
         tag       <= '0;
         err       <= 1'b0;
      end else begin
         if (state != IDLE && state != HOLD && rd_cpl_valid)
            rcvd <= rcvd + {25'd0, rd_cpl_qwords};
         unique case (state)
            IDLE: begin
               if (pick_1) begin
                  cur_page  <= 1'b0;
                  cur_addr  <= huge_page_addr_1;
                  remaining <= huge_page_qwords_1;
                  expected  <= huge_page_qwords_1;
                  rcvd      <= '0;
               end else if (pick_2) begin
                  cur_page  <= 1'b1;
                  cur_addr  <= huge_page_addr_2;
                  remaining <= huge_page_qwords_2;
                  expected  <= huge_page_qwords_2;
                  rcvd      <= '0;
               end
            end
            SEL: chunk <= chunk_c[6:0];
            HDR1: begin
               if (xfer) begin
                  cur_addr  <= cur_addr + {54'd0, chunk, 3'b000};
                  remaining <= remaining - {25'd0, chunk};
                  tag       <= tag + 5'd1;
               end
            end
            WAIT_CPL: if (rcvd > {1'b0, expected}) err <= 1'b1;
            RELEASE:  next_page <= !cur_page;
            default: ;
         endcase
      end
   end

   always_comb begin
      trn_td = '0;
      unique case (state)
         HDR0: trn_td = {1'b0, 7'b0100000, 8'h00, 6'b000000, len_dw,
                         cfg_completer_id, 3'b000, tag, 4'hF, 4'hF};
         HDR1: trn_td = {cur_addr[63:3], 3'b000};
         default: ;
      endcase
   end

   assign trn_trem_n          = 8'h00;
   assign trn_tsof_n          = (state != HDR0);
   assign trn_teof_n          = (state != HDR1);
   assign trn_tsrc_rdy_n      = !(state == HDR0 || state == HDR1);
   assign huge_page_to_host_1 = (state == RELEASE) && !cur_page;
   assign huge_page_to_host_2 = (state == RELEASE) && cur_page;
   assign err_cpl_overflow    = err;

endmodule
